// File: rtl/mem_stage.sv
// mem_stage -- memory-access stage of the integer pipeline.
//
// Decodes RV64 loads and stores, issues one data-memory request per aligned
// access, and holds the upstream pipeline with stall_o until the memory
// acknowledges. Non-memory instructions pass to WB with one cycle of latency.
// Misaligned accesses are dropped: they raise misalign_o for one cycle and
// retire without any register or CSR write.
//
// Ports:
//   clk, rst                clock, asynchronous active-low reset
//   valid_i .. csr_wdata_i  instruction fields from the EX/MEM register
//   dmem_*_o                registered data-memory request (addr/data/mask)
//   dmem_rdata_i, dmem_ack_i  memory response, sampled only while BUSY
//   stall_o                 holds EX/MEM and every earlier stage
//   misalign_o              one-cycle misaligned-access pulse
//   wb_*_o                  registered results towards WB
//   mem_back_*_o            the same results forwarded back to EX
module mem_stage #(
  parameter int DW = 64,
  parameter int MW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          valid_i,
  input  logic [6:0]    opcode_i,
  input  logic [2:0]    funct3_i,
  input  logic [4:0]    rd_addr_i,
  input  logic          wreg_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [DW-1:0] store_data_i,
  input  logic [11:0]   csr_waddr_i,
  input  logic          csr_wreg_i,
  input  logic [DW-1:0] csr_wdata_i,
  output logic          dmem_req_o,
  output logic          dmem_we_o,
  output logic [DW-1:0] dmem_addr_o,
  output logic [DW-1:0] dmem_wdata_o,
  output logic [MW-1:0] dmem_wmask_o,
  input  logic [DW-1:0] dmem_rdata_i,
  input  logic          dmem_ack_i,
  output logic          stall_o,
  output logic          misalign_o,
  output logic [4:0]    wb_rd_addr_o,
  output logic          wb_wreg_o,
  output logic [DW-1:0] wb_wdata_o,
  output logic [11:0]   wb_csr_waddr_o,
  output logic          wb_csr_wreg_o,
  output logic [DW-1:0] wb_csr_wdata_o,
  output logic [4:0]    mem_back_rd_addr_o,
  output logic          mem_back_wreg_o,
  output logic [DW-1:0] mem_back_wdata_o,
  output logic [11:0]   mem_back_csr_waddr_o,
  output logic          mem_back_csr_wreg_o,
  output logic [DW-1:0] mem_back_csr_wdata_o
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef enum logic {IDLE, BUSY} state_t;
  state_t state, state_next;

  logic       is_load, is_store, is_mem, misaligned, start;
  logic [2:0] lane;

  // Load context captured when the request is issued, used at retirement.
  logic [4:0] rd_addr_p1;
  logic       wreg_p1;
  logic       load_p1;
  logic [2:0] funct3_p1;
  logic [2:0] lane_p1;

  // Select the addressed lane and sign- or zero-extend it to DW bits.
  function automatic logic [DW-1:0] load_extract(input logic [DW-1:0] rdata,
                                                 input logic [2:0]    f3,
                                                 input logic [2:0]    ln);
    logic [DW-1:0]      s;
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] w;
    logic [DW-1:0]      r;
    s = rdata >> {ln, 3'b000};
    b = s[7:0];
    h = s[15:0];
    w = s[31:0];
    case (f3)
      3'b000:  r = DW'(b);
      3'b001:  r = DW'(h);
      3'b010:  r = DW'(w);
      3'b100:  r = DW'(s[7:0]);
      3'b101:  r = DW'(s[15:0]);
      3'b110:  r = DW'(s[31:0]);
      default: r = s;
    endcase
    return r;
  endfunction

  function automatic logic [MW-1:0] store_mask(input logic [1:0] size,
                                               input logic [2:0] ln);
    logic [MW-1:0] m;
    m = '0;
    case (size)
      2'b00:   m[0]   = 1'b1;
      2'b01:   m[1:0] = 2'b11;
      2'b10:   m[3:0] = 4'hF;
      default: m      = '1;
    endcase
    return m << ln;
  endfunction

  assign lane = wdata_i[2:0];

  always_comb begin
    is_load    = (opcode_i == OP_LOAD) && (funct3_i != 3'b111);
    is_store   = (opcode_i == OP_STORE) && !funct3_i[2];
    is_mem     = is_load || is_store;
    misaligned = 1'b0;
    case (funct3_i[1:0])
      2'b01:   misaligned = lane[0];
      2'b10:   misaligned = |lane[1:0];
      2'b11:   misaligned = |lane;
      default: misaligned = 1'b0;
    endcase
  end

  assign start = (state == IDLE) && valid_i && is_mem && !misaligned;

  // Gated by rst so the stall is forced low while reset is held.
  assign stall_o = rst && (start || ((state == BUSY) && !dmem_ack_i));

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = BUSY;
      BUSY:    if (dmem_ack_i) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ---- stage p1: request issue, FSM, retirement towards WB ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      dmem_req_o     <= 1'b0;
      dmem_we_o      <= 1'b0;
      dmem_addr_o    <= '0;
      dmem_wdata_o   <= '0;
      dmem_wmask_o   <= '0;
      misalign_o     <= 1'b0;
      wb_rd_addr_o   <= '0;
      wb_wreg_o      <= 1'b0;
      wb_wdata_o     <= '0;
      wb_csr_waddr_o <= '0;
      wb_csr_wreg_o  <= 1'b0;
      wb_csr_wdata_o <= '0;
    end else begin
      state      <= state_next;
      misalign_o <= (state == IDLE) && valid_i && is_mem && misaligned;

      // Request registers: loaded on issue, held through BUSY, cleared after ack.
      if (start) begin
        dmem_req_o   <= 1'b1;
        dmem_we_o    <= is_store;
        dmem_addr_o  <= {wdata_i[DW-1:3], 3'b000};
        dmem_wdata_o <= is_store ? (store_data_i << {lane, 3'b000}) : '0;
        dmem_wmask_o <= is_store ? store_mask(funct3_i[1:0], lane) : '0;
      end else if ((state == IDLE) || dmem_ack_i) begin
        dmem_req_o   <= 1'b0;
        dmem_we_o    <= 1'b0;
        dmem_addr_o  <= '0;
        dmem_wdata_o <= '0;
        dmem_wmask_o <= '0;
      end

      if (state == BUSY) begin
        // Only the ack edge retires; every waiting edge loads a bubble.
        wb_wreg_o     <= dmem_ack_i && load_p1 && wreg_p1 && (rd_addr_p1 != 5'd0);
        wb_csr_wreg_o <= 1'b0;
        if (dmem_ack_i) begin
          wb_rd_addr_o <= rd_addr_p1;
          wb_wdata_o   <= load_p1 ? load_extract(dmem_rdata_i, funct3_p1, lane_p1) : '0;
        end
      end else if (!valid_i || start) begin
        wb_wreg_o     <= 1'b0;
        wb_csr_wreg_o <= 1'b0;
      end else begin
        // Non-memory op, or a misaligned access retiring without writes.
        wb_rd_addr_o   <= rd_addr_i;
        wb_wreg_o      <= !is_mem && wreg_i && (rd_addr_i != 5'd0);
        wb_wdata_o     <= wdata_i;
        wb_csr_waddr_o <= csr_waddr_i;
        wb_csr_wreg_o  <= !is_mem && csr_wreg_i;
        wb_csr_wdata_o <= csr_wdata_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (start) begin
      rd_addr_p1 <= rd_addr_i;
      wreg_p1    <= wreg_i;
      load_p1    <= is_load;
      funct3_p1  <= funct3_i;
      lane_p1    <= lane;
    end
  end

  assign mem_back_rd_addr_o   = wb_rd_addr_o;
  assign mem_back_wreg_o      = wb_wreg_o;
  assign mem_back_wdata_o     = wb_wdata_o;
  assign mem_back_csr_waddr_o = wb_csr_waddr_o;
  assign mem_back_csr_wreg_o  = wb_csr_wreg_o;
  assign mem_back_csr_wdata_o = wb_csr_wdata_o;

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL use one clock and one reset. The reset is asynchronous and active-low. The ports are named clk and rst, as in the rest of the codebase.
REQ-002 SHALL have these parameters (name, default, meaning): DW, 64, data/address width; MW, 8, byte-mask width (DW/8).
REQ-003 SHALL have these ports (name, direction, width, meaning):
- clk  in  1  clock
- rst  in  1  async active-low reset
- valid_i  in  1  instruction present from the EX/MEM register
- opcode_i  in  7  instruction opcode
- funct3_i  in  3  width/sign select
- rd_addr_i  in  5  destination register
- wreg_i  in  1  rd write enable
- wdata_i  in  DW  ALU result; for loads/stores this is the effective address
- store_data_i  in  DW  rs2 value for stores
- csr_waddr_i  in  12  CSR destination
- csr_wreg_i  in  1  CSR write enable
- csr_wdata_i  in  DW  CSR write value
- dmem_req_o  out  1  data-memory request
- dmem_we_o  out  1  1 = store
- dmem_addr_o  out  DW  doubleword-aligned address {addr[63:3],3'b0}
- dmem_wdata_o  out  DW  store data shifted into byte lanes
- dmem_wmask_o  out  MW  byte-lane enable
- dmem_rdata_i  in  DW  load data
- dmem_ack_i  in  1  request completed this cycle
- stall_o  out  1  hold EX/MEM and all upstream stages
- misalign_o  out  1  one-cycle misaligned-access pulse
- wb_rd_addr_o  out  5  registered to WB
- wb_wreg_o  out  1  registered to WB
- wb_wdata_o  out  DW  registered to WB
- wb_csr_waddr_o  out  12  registered to WB
- wb_csr_wreg_o  out  1  registered to WB
- wb_csr_wdata_o  out  DW  registered to WB
- mem_back_rd_addr_o  out  5  forwarding to EX; equals wb_rd_addr_o
- mem_back_wreg_o  out  1  forwarding to EX; equals wb_wreg_o
- mem_back_wdata_o  out  DW  forwarding to EX; equals wb_wdata_o
- mem_back_csr_waddr_o  out  12  forwarding to EX; equals wb_csr_waddr_o
- mem_back_csr_wreg_o  out  1  forwarding to EX; equals wb_csr_wreg_o
- mem_back_csr_wdata_o  out  DW  forwarding to EX; equals wb_csr_wdata_o

Function
REQ-004 SHALL decode the access type:
- load: opcode 0000011; funct3 000 LB, 001 LH, 010 LW, 011 LD, 100 LBU, 101 LHU, 110 LWU.
- store: opcode 0100011; funct3 000 SB, 001 SH, 010 SW, 011 SD.
- any other opcode: non-memory instruction.
REQ-005 SHALL implement a two-state FSM, IDLE and BUSY:
- IDLE to BUSY when valid_i is 1 and the instruction is an aligned load or store.
- BUSY to IDLE on a cycle with dmem_ack_i = 1.
REQ-006 SHALL drive dmem_req_o and the other dmem_* outputs as registered signals. They are 1/valid for every BUSY cycle, including the ack cycle, and are held stable while in BUSY.
REQ-007 SHALL compute stall_o combinationally as:
(IDLE & valid_i & aligned mem op) | (BUSY & ~dmem_ack_i).
REQ-008 SHALL give a non-memory instruction one-cycle latency: wb_* load its rd/csr fields and wdata_i at the next clock edge.
REQ-009 SHALL give a memory op a latency of (ack cycle + 1 edge); wb_* load at the edge where dmem_ack_i = 1 is sampled in BUSY.
REQ-010 SHALL extract load data by lane = addr[2:0]:
- byte: rdata[8*lane+:8]
- half: rdata[8*lane+:16]
- word: rdata[8*lane+:32]
- LB/LH/LW sign-extend to 64 bits; LBU/LHU/LWU zero-extend; LD passes all 64 bits.
REQ-011 SHALL generate stores as:
- dmem_wdata_o = store_data_i << (8*addr[2:0])
- dmem_wmask_o = 0x01 / 0x03 / 0x0F / 0xFF (SB/SH/SW/SD) << addr[2:0]
- dmem_we_o = 1
REQ-012 SHALL retire a store with wb_wreg_o = 0.
REQ-013 SHALL treat these as misaligned: half with addr[0]≠0, word with addr[1:0]≠0, double with addr[2:0]≠0.
REQ-014 SHALL handle a misaligned access as follows: no request, no stall, misalign_o = 1 at the next edge for one cycle, and the instruction retires with wb_wreg_o = 0 and wb_csr_wreg_o = 0.
REQ-015 SHALL load a bubble (wb_wreg_o = 0, wb_csr_wreg_o = 0) into the wb_* registers on every edge where stall_o = 1 or valid_i = 0, so that a held instruction never writes twice.
REQ-016 SHALL force wb_wreg_o to 0 whenever rd_addr_i = 0.
REQ-017 SHALL ignore dmem_ack_i and dmem_rdata_i while in IDLE.
REQ-018 SHALL pass CSR fields (csr_waddr_i, csr_wreg_i, csr_wdata_i) through unchanged for non-memory instructions.

Reset
REQ-019 SHALL, while rst = 0 (asynchronously), force: FSM = IDLE; all dmem_* outputs, wb_*, misalign_o and stall_o = 0.
REQ-020 SHALL handle reset during BUSY by abandoning the access without retiring it; an ack arriving after reset release is ignored per REQ-017.

Verification
REQ-021 SHALL cover: ADD retire, valid_i = 1, rd = 5, wdata_i = 0x1234 -> next edge wb_rd_addr_o = 5, wb_wreg_o = 1, wb_wdata_o = 0x1234, stall_o = 0 throughout.
REQ-022 SHALL cover: LB with a 2-cycle ack wait, addr 0x1003, dmem_rdata_i = 0x00000000_80000000, ack on the 3rd BUSY cycle -> dmem_addr_o = 0x1000, stall_o = 1 for 3 cycles, wb_wdata_o = 0xFFFFFFFF_FFFFFF80.
REQ-023 SHALL cover: SH, addr 0x2006, store_data_i = 0xABCD, ack on the 1st BUSY cycle -> dmem_wmask_o = 0xC0, dmem_wdata_o = 0xABCD0000_00000000, wb_wreg_o = 0.
REQ-024 SHALL cover: LW at addr 0x3002 -> dmem_req_o stays 0, misalign_o pulses for 1 cycle, wb_wreg_o = 0.
REQ-025 SHALL cover: rst = 0 asserted during BUSY, then ack = 1 after release -> dmem_req_o = 0 immediately, FSM = IDLE, no retire, wb_wreg_o = 0.
